// File: rtl/free_entry_allocator_pkg.sv
// Shared types for the free-entry allocator and its consumers.
package free_entry_allocator_pkg;

  localparam int unsigned POOL_WIDTH = 16;
  localparam int unsigned INDEX_W    = $clog2(POOL_WIDTH);

  typedef logic [INDEX_W-1:0] alloc_index_t;

endpackage

// File: rtl/free_entry_allocator_if.sv
// Requester/releaser bundle of the free-entry allocator.
interface free_entry_allocator_if #(
  parameter int unsigned WIDTH = free_entry_allocator_pkg::POOL_WIDTH
);
  localparam int unsigned IW = $clog2(WIDTH);

  // alloc_req is the valid and alloc_grant the same-cycle ready: a transfer happens
  // on an edge where both are 1, and the requester keeps alloc_req high until granted.
  logic          flush;
  logic          alloc_req;
  logic          alloc_grant;
  logic [IW-1:0] alloc_index;
  logic          release_valid;
  logic [IW-1:0] release_index;
  logic          full;
  logic          empty;
  logic [IW:0]   free_count;
  logic          release_error;

  modport master (
    output flush, alloc_req, release_valid, release_index,
    input  alloc_grant, alloc_index, full, empty, free_count, release_error
  );

  modport slave (
    input  flush, alloc_req, release_valid, release_index,
    output alloc_grant, alloc_index, full, empty, free_count, release_error
  );
endinterface

// File: rtl/free_entry_allocator_priority_finder.sv
// Picks the lowest (FIRST_PRIORITY=1) or highest (0) set bit of a vector.
module priority_finder #(
  parameter int unsigned WIDTH          = 16,
  parameter bit          FIRST_PRIORITY = 1'b1
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] index_o,
  output logic                     any_o
);
  localparam int unsigned IW = $clog2(WIDTH);

  // The last matching assignment wins, so the scan direction sets the priority.
  always_comb begin
    index_o = '0;
    if (FIRST_PRIORITY) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (vec_i[i]) index_o = IW'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (vec_i[i]) index_o = IW'(i);
      end
    end
  end

  assign any_o = |vec_i;
endmodule

// File: rtl/free_entry_allocator.sv
// Busy/free tracker that grants one free entry per cycle and accepts one release.
// Define ALLOCATOR_FREE_COUNT_EN to maintain free_count and self-check it.
module free_entry_allocator
  import free_entry_allocator_pkg::*;
#(
  parameter int unsigned WIDTH          = POOL_WIDTH,
  parameter bit          FIRST_PRIORITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  free_entry_allocator_if.slave bus
);
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = IW + 1;

  logic [WIDTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] free_vec, grant_mask, release_mask;
  logic [IW-1:0]    find_index;
  logic             any_free, grant, release_ok, release_bad;
  logic             full_q, empty_q, release_error_q;

  assign free_vec = ~busy_q;

  priority_finder #(
    .WIDTH          (WIDTH),
    .FIRST_PRIORITY (FIRST_PRIORITY)
  ) u_finder (
    .vec_i   (free_vec),
    .index_o (find_index),
    .any_o   (any_free)
  );

  assign grant       = bus.alloc_req && any_free && !bus.flush;
  assign release_ok  = bus.release_valid && !bus.flush && busy_q[bus.release_index];
  assign release_bad = bus.release_valid && !bus.flush && !busy_q[bus.release_index];

  // The finder only sees free entries and a valid release targets a busy one,
  // so the two masks never overlap.
  always_comb begin
    grant_mask   = '0;
    release_mask = '0;
    if (grant)      grant_mask[find_index]          = 1'b1;
    if (release_ok) release_mask[bus.release_index] = 1'b1;
    busy_d = bus.flush ? '0 : ((busy_q | grant_mask) & ~release_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      release_error_q <= 1'b0;
    end else begin
      busy_q          <= busy_d;
      full_q          <= &busy_d;
      empty_q         <= ~|busy_d;
      release_error_q <= release_error_q | release_bad;
    end
  end

  assign bus.alloc_grant   = grant;
  assign bus.alloc_index   = find_index;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.release_error = release_error_q;

`ifdef ALLOCATOR_FREE_COUNT_EN
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q - CW'(grant) + CW'(release_ok);
    if (bus.flush) count_d = CW'(WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= CW'(WIDTH);
    else     count_q <= count_d;
  end

  assign bus.free_count = count_q;

  free_count_matches_pool : assert property (
    @(posedge clk) disable iff (rst) count_q == CW'($countones(free_vec))
  );
`else
  assign bus.free_count = '0;
`endif
endmodule

// File: tb/tb_free_entry_allocator.sv
// Directed bench: vector table on two WIDTH=4 allocators (lowest/highest first).
module tb_free_entry_allocator;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  free_entry_allocator_if #(.WIDTH(4)) bus_a ();
  free_entry_allocator_if #(.WIDTH(4)) bus_b ();

  free_entry_allocator #(.WIDTH(4), .FIRST_PRIORITY(1'b1)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a.slave)
  );
  free_entry_allocator #(.WIDTH(4), .FIRST_PRIORITY(1'b0)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b.slave)
  );

  typedef struct {
    bit       sel;
    bit       rst, flush, req, rel;
    bit [1:0] ridx;
    bit       g;
    bit [1:0] idx;
    bit       full, empty;
    int       fc;
    bit       err;
  } vec_t;

  vec_t tbl[$];

  function automatic int exp_fc(input int c);
`ifdef ALLOCATOR_FREE_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic void add(input bit sel, input bit rst, input bit flush, input bit req,
                              input bit rel, input bit [1:0] ridx, input bit g,
                              input bit [1:0] idx, input bit full, input bit empty,
                              input int fc, input bit err);
    vec_t t;
    t.sel = sel; t.rst = rst; t.flush = flush; t.req = req; t.rel = rel; t.ridx = ridx;
    t.g = g; t.idx = idx; t.full = full; t.empty = empty; t.fc = fc; t.err = err;
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_a = 1'b0; bus_a.flush = 1'b0; bus_a.alloc_req = 1'b0;
    bus_a.release_valid = 1'b0; bus_a.release_index = '0;
    rst_b = 1'b0; bus_b.flush = 1'b0; bus_b.alloc_req = 1'b0;
    bus_b.release_valid = 1'b0; bus_b.release_index = '0;
    if (t.sel) begin
      rst_b = t.rst; bus_b.flush = t.flush; bus_b.alloc_req = t.req;
      bus_b.release_valid = t.rel; bus_b.release_index = t.ridx;
    end else begin
      rst_a = t.rst; bus_a.flush = t.flush; bus_a.alloc_req = t.req;
      bus_a.release_valid = t.rel; bus_a.release_index = t.ridx;
    end
  endtask

  task automatic apply(input int n, input vec_t t);
    drive(t);
    #2;
    check($sformatf("v%0d grant", n), t.sel ? bus_b.alloc_grant : bus_a.alloc_grant, t.g);
    if (t.g)
      check($sformatf("v%0d index", n), t.sel ? bus_b.alloc_index : bus_a.alloc_index, t.idx);
    @(posedge clk);
    #1;
    check($sformatf("v%0d full", n), t.sel ? bus_b.full : bus_a.full, t.full);
    check($sformatf("v%0d empty", n), t.sel ? bus_b.empty : bus_a.empty, t.empty);
    check($sformatf("v%0d free_count", n),
          t.sel ? int'(bus_b.free_count) : int'(bus_a.free_count), exp_fc(t.fc));
    check($sformatf("v%0d release_error", n),
          t.sel ? bus_b.release_error : bus_a.release_error, t.err);
  endtask

  initial begin
    vec_t idle;
    idle = '{default: 0};
    drive(idle);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //  sel rst fl req rel ridx | g idx full empty fc err
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 4, 0);
    add(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0);
    add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 2, 0);
    add(0, 0, 0, 1, 0, 0,  1, 2, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  1, 3, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 2,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 2,  0, 0, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 3,  0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 1, 1, 1,  1, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4, 1);
    add(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 4, 1);
    add(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 3, 1);
    add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 2, 1);
    add(0, 0, 0, 1, 0, 0,  1, 2, 0, 0, 1, 1);
    add(0, 0, 1, 1, 1, 1,  0, 0, 0, 1, 4, 1);
    add(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 3, 1);
    add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 2, 1);
    add(0, 1, 1, 1, 1, 0,  0, 0, 0, 1, 4, 0);
    add(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0);
    add(0, 1, 0, 1, 0, 0,  1, 1, 0, 1, 4, 0);
    add(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0);
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 4, 0);
    add(1, 0, 0, 1, 0, 0,  1, 3, 0, 0, 3, 0);
    add(1, 0, 0, 1, 0, 0,  1, 2, 0, 0, 2, 0);

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // Highest-first allocator keeps handing out distinct descending indices until full.
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    drive(idle);
    bus_b.alloc_req = 1'b1;
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      #2;
      check("seq_b grant", bus_b.alloc_grant, 1);
      check("seq_b index", bus_b.alloc_index, e);
      @(posedge clk);
      #1;
    end
    check("seq_b full", bus_b.full, 1);
    check("seq_b free_count", int'(bus_b.free_count), exp_fc(0));
    #2;
    check("seq_b grant when full", bus_b.alloc_grant, 0);
    @(posedge clk);
    #1;
    check("seq_b still full", bus_b.full, 1);
    drive(idle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
